risc_sequencer: RTL
===================

RISC_SEQUENCER -- requirements
Module: risc_sequencer

Interface
REQ-001 Parameters: none; opcode width fixed at 3, phase count fixed at 8.
REQ-002 CLK  input  1  clock; all state changes on posedge.
REQ-003 RST_  input  1  reset, asynchronous, active-low.
REQ-004 OPCODE  input  3  instruction-register opcode; stable from phase 3 to end of instruction.
REQ-005 ZERO  input  1  accumulator-is-zero flag.
REQ-006 PHASE  output  3  current phase, 0..7.
REQ-007 SEL  output  1  memory address mux: 1 = PC, 0 = IR operand.
REQ-008 RD  output  1  memory read strobe.
REQ-009 LD_IR  output  1  instruction-register load.
REQ-010 INC_PC  output  1  PC increment request.
REQ-011 LD_PC  output  1  PC load request (jump).
REQ-012 PC_EN  output  1  PC counter enable; equals INC_PC | LD_PC; LD_PC drives PC counter LD.
REQ-013 DATA_E  output  1  accumulator drive onto data bus.
REQ-014 LD_AC  output  1  accumulator load.
REQ-015 WR  output  1  memory write strobe.
REQ-016 HALT  output  1  processor halted indication.

Function
REQ-017 Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7; ALUOP = ADD|AND|XOR|LDA.
REQ-018 Phase register advances by 1 each cycle and wraps 7->0 (mod 8); phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
REQ-019 Output decode, combinational from PHASE, OPCODE, ZERO; any output not listed is 0:
- Phase 0: SEL.
- Phase 1: SEL, RD.
- Phase 2 and 3: SEL, RD, LD_IR.
- Phase 4: INC_PC; HALT if OPCODE==HLT.
- Phase 5: RD if ALUOP.
- Phase 6: RD if ALUOP; INC_PC if SKZ and ZERO; LD_PC if JMP; DATA_E if STO.
- Phase 7: RD and LD_AC if ALUOP; LD_PC if JMP; WR and DATA_E if STO.
REQ-020 HALT in phase 4 sets a sticky halted flag at that posedge; once set, the phase holds at 4, HALT stays 1, and all other strobes are 0.
REQ-021 Halted state is left only by reset (see REQ-026 for the macro exception).
REQ-022 INC_PC and LD_PC are never both 1; WR and RD are never both 1.
REQ-023 One instruction takes exactly 8 cycles; SKZ taken adds one PC increment (phase 4 plus phase 6).

Reset
REQ-024 RST_ low: PHASE=0, halted flag=0, step-hold flag=0, immediately and asynchronously.
REQ-025 Reset at any phase aborts the instruction; first cycle after release is phase 0 with SEL=1 and all other strobes 0.

Configuration
REQ-026 Macro SEQ_SINGLE_STEP_EN adds input STEP (1 bit).
- Defined: after phase 7 the sequencer holds at phase 0 with all strobes 0 except SEL, until a cycle with STEP=1; phase 1 follows that cycle.
- Defined: STEP=1 while halted clears the halted flag, and phase 5 follows.
- Undefined: the STEP port is absent and the behaviour follows REQ-018 to REQ-021 only.

Structure
REQ-027 Package risc_pkg holds the opcode enum (3 bits), the phase enum (3 bits), and the ALUOP membership function.
REQ-028 Sub-module seq_decode implements the REQ-019 combinational decode; risc_sequencer holds the phase register, the halted flag, the step logic and PC_EN.

Verification
REQ-029 Scenario: reset, then OPCODE=ADD for 8 cycles. Required: PHASE 0..7; RD in phases 1,2,3,5,6,7; LD_AC only in phase 7; INC_PC only in phase 4.
REQ-030 Scenario: OPCODE=SKZ with ZERO=1, then with ZERO=0. Required: INC_PC in phases 4 and 6 for the first; phase 4 only for the second.
REQ-031 Scenario: OPCODE=JMP. Required: LD_PC=1 and PC_EN=1 in phases 6 and 7; INC_PC=1 in phase 4 only.
REQ-032 Scenario: OPCODE=STO. Required: DATA_E in phases 6 and 7; WR in phase 7 only; RD=0 in phases 5 to 7.
REQ-033 Scenario: OPCODE=HLT, held 20 cycles, then RST_ pulsed low mid-cycle. Required: PHASE stuck at 4 with HALT=1; immediate PHASE=0 and HALT=0 on reset.
REQ-034 Scenario: SEQ_SINGLE_STEP_EN defined, STEP=0 for 5 cycles after the first instruction, then STEP=1. Required: PHASE=0 held for 5 cycles, then PHASE=1.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: opcode and phase encodings, control-word layout and ALU-opcode test
// shared by the RISC sequencer and its decoder.
package risc_pkg;

    typedef enum logic [2:0] {
        OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
    } opcode_e;

    typedef enum logic [2:0] {
        PH_INST_ADDR, PH_INST_FETCH, PH_INST_LOAD, PH_IDLE,
        PH_OP_ADDR, PH_OP_FETCH, PH_ALU_OP, PH_STORE
    } phase_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic data_e;
        logic ld_ac;
        logic wr;
        logic halt;
    } ctrl_t;

    function automatic logic is_aluop(opcode_e op);
        return op inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    endfunction

endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational control-strobe decode from the current phase,
// the instruction opcode and the accumulator-zero flag.
module seq_decode
    import risc_pkg::*;
(
    input  phase_e  phase_i,
    input  opcode_e opcode_i,
    input  logic    zero_i,
    output ctrl_t   ctrl_o
);

    logic alu, sto, jmp;

    assign alu = is_aluop(opcode_i);
    assign sto = (opcode_i == OP_STO);
    assign jmp = (opcode_i == OP_JMP);

    always_comb begin
        ctrl_o = '0;
        case (phase_i)
            PH_INST_ADDR: ctrl_o.sel = 1'b1;
            PH_INST_FETCH: begin
                ctrl_o.sel = 1'b1;
                ctrl_o.rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                ctrl_o.sel   = 1'b1;
                ctrl_o.rd    = 1'b1;
                ctrl_o.ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                ctrl_o.inc_pc = 1'b1;
                ctrl_o.halt   = (opcode_i == OP_HLT);
            end
            PH_OP_FETCH: ctrl_o.rd = alu;
            PH_ALU_OP: begin
                ctrl_o.rd     = alu;
                ctrl_o.inc_pc = (opcode_i == OP_SKZ) && zero_i;
                ctrl_o.ld_pc  = jmp;
                ctrl_o.data_e = sto;
            end
            PH_STORE: begin
                ctrl_o.rd     = alu;
                ctrl_o.ld_ac  = alu;
                ctrl_o.ld_pc  = jmp;
                ctrl_o.wr     = sto;
                ctrl_o.data_e = sto;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/risc_sequencer.sv
// risc_sequencer: 8-phase instruction sequencer with sticky halt.
// Define SEQ_SINGLE_STEP_EN to add the STEP input for single-instruction stepping.
module risc_sequencer
    import risc_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_,
    input  logic [2:0] OPCODE,
    input  logic       ZERO,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       STEP,
`endif
    output logic [2:0] PHASE,
    output logic       SEL,
    output logic       RD,
    output logic       LD_IR,
    output logic       INC_PC,
    output logic       LD_PC,
    output logic       PC_EN,
    output logic       DATA_E,
    output logic       LD_AC,
    output logic       WR,
    output logic       HALT
);

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   resume, wait_step;
    ctrl_t  dec, ctrl;

    seq_decode u_decode (
        .phase_i  (phase_q),
        .opcode_i (opcode_e'(OPCODE)),
        .zero_i   (ZERO),
        .ctrl_o   (dec)
    );

`ifdef SEQ_SINGLE_STEP_EN
    logic hold_q, hold_d;

    // Set when an instruction completes; parks the sequencer in phase 0 until STEP.
    assign resume    = STEP;
    assign wait_step = hold_q & ~STEP;
    assign hold_d    = (phase_q == PH_STORE) | wait_step;

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) hold_q <= 1'b0;
        else       hold_q <= hold_d;
    end
`else
    assign resume    = 1'b0;
    assign wait_step = 1'b0;
`endif

    // dec.halt can only be raised in phase 4, so it doubles as the halt-entry condition.
    always_comb begin
        phase_d  = halted_q ? (resume ? PH_OP_FETCH : PH_OP_ADDR)
                 : (dec.halt | wait_step) ? phase_q
                 : phase_e'(phase_q + 3'd1);
        halted_d = halted_q ? ~resume : dec.halt;
        ctrl     = halted_q ? '{halt: 1'b1, default: 1'b0} : dec;
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    assign PHASE  = phase_q;
    assign SEL    = ctrl.sel;
    assign RD     = ctrl.rd;
    assign LD_IR  = ctrl.ld_ir;
    assign INC_PC = ctrl.inc_pc;
    assign LD_PC  = ctrl.ld_pc;
    assign PC_EN  = ctrl.inc_pc | ctrl.ld_pc;
    assign DATA_E = ctrl.data_e;
    assign LD_AC  = ctrl.ld_ac;
    assign WR     = ctrl.wr;
    assign HALT   = ctrl.halt;

endmodule
